mem_access_ctrl: RTL and testbench

- Initiator side of the data-memory interface. Sits between the CPU pipeline MEM stage and the data memory.
- Turns pipeline load/store requests (word or byte, signed or unsigned) into memory address/write-data/write-enable sequences. Samples read data after a fixed memory latency and returns it with a one-cycle response pulse.
- Byte stores are done as read-modify-write because the memory only writes whole 16-bit words.

---
 rtl/mem_access_ctrl_if.sv | 37 +++
 rtl/mem_access_ctrl.sv | 76 +++++++
 tb/tb_mem_access_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: pipeline request/response and data-memory bus bundle.
// resp_err exists only when ALIGN_CHECK_EN is defined.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_write;
    logic              req_byte;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [15:0]       resp_rdata;
    logic              stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [1:0]        mem_write;
    logic [15:0]       mem_rdata;
`ifdef ALIGN_CHECK_EN
    logic              resp_err;
`endif
    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, mem_rdata,
`ifdef ALIGN_CHECK_EN
        output resp_err,
`endif
        output req_ready, resp_valid, resp_rdata, stall, mem_addr, mem_wdata, mem_write
    );
    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, mem_rdata,
`ifdef ALIGN_CHECK_EN
        input  resp_err,
`endif
        input  req_ready, resp_valid, resp_rdata, stall, mem_addr, mem_wdata, mem_write
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: data-memory initiator; word/byte loads and stores, byte store as read-modify-write.
// ALIGN_CHECK_EN: misaligned word accesses answer at once with resp_err and no memory access.
module mem_access_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input logic          clk,
    input logic          reset,
    mem_access_ctrl_if.slave bus
);
    localparam int CW = $clog2(MEM_LAT + 1);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;
    state_t            state, nxt;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q, rdata_q;
    logic              write_q, byte_q, signed_q, mis, last;
`ifdef ALIGN_CHECK_EN
    logic              err_q;
    assign mis          = ~bus.req_byte & bus.req_addr[0];
    assign bus.resp_err = err_q;
`else
    assign mis = 1'b0;
`endif
    assign last           = cnt == CW'(1);
    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.stall      = bus.req_valid & ~bus.resp_valid;
    assign bus.mem_write  = {1'b0, state == WR};
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.resp_rdata = rdata_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) nxt = mis ? RESP : (bus.req_write & ~bus.req_byte) ? WR : RD_WAIT;
            RD_WAIT: if (last) nxt = write_q ? WR : RESP;
            WR:      nxt = RESP;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
`ifdef ALIGN_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else if (state == IDLE && bus.req_valid) begin
            if (!mis) addr_q <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            write_q  <= bus.req_write;
            byte_q   <= bus.req_byte;
            signed_q <= bus.req_signed;
            cnt      <= CW'(MEM_LAT);
`ifdef ALIGN_CHECK_EN
            err_q    <= mis;
            if (mis) rdata_q <= '0;
`endif
        end else if (state == RD_WAIT) begin
            cnt <= cnt - 1'b1;
            // byte store keeps byte A+1 by writing back the low half just read
            if (last && write_q) wdata_q <= {wdata_q[7:0], bus.mem_rdata[7:0]};
            else if (last) rdata_q <= byte_q ? {{8{signed_q & bus.mem_rdata[15]}}, bus.mem_rdata[15:8]} : bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vectors on two controllers (MEM_LAT=1 and MEM_LAT=3) sharing stimulus.
// Each controller has its own big-endian byte memory model with the matching read latency.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic init = 1'b1;
    int   nvec = 0;
    int   nbad = 0;
    mem_access_ctrl_if #(.ADDR_W(16)) b1 ();
    mem_access_ctrl_if #(.ADDR_W(16)) b3 ();
    mem_access_ctrl #(.ADDR_W(16), .MEM_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
    mem_access_ctrl #(.ADDR_W(16), .MEM_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(b3));
    always #5 clk = ~clk;
    logic [7:0]  m1 [0:65535];
    logic [7:0]  m3 [0:65535];
    logic [15:0] a1n, a3n, p1, p2;
    assign a1n = b1.mem_addr + 16'd1;
    assign a3n = b3.mem_addr + 16'd1;
    assign b1.mem_rdata = {m1[b1.mem_addr], m1[a1n]};
    assign b3.mem_rdata = p2;
    always @(posedge clk) begin
        p1 <= {m3[b3.mem_addr], m3[a3n]};
        p2 <= p1;
        if (init) begin
            m1[16'h0000] <= 8'h2B; m1[16'h0001] <= 8'hCD; m1[16'h0010] <= 8'h00; m1[16'h0011] <= 8'h00;
            m1[16'h0012] <= 8'h5E; m1[16'h0020] <= 8'h80; m1[16'h0021] <= 8'h11; m1[16'hFFFF] <= 8'h77;
            m3[16'h0000] <= 8'h2B; m3[16'h0001] <= 8'hCD; m3[16'h0010] <= 8'h00; m3[16'h0011] <= 8'h00;
            m3[16'h0012] <= 8'h5E; m3[16'h0020] <= 8'h80; m3[16'h0021] <= 8'h11; m3[16'hFFFF] <= 8'h77;
        end else begin
            if (b1.mem_write == 2'b01) begin
                m1[b1.mem_addr] <= b1.mem_wdata[15:8];
                m1[a1n]         <= b1.mem_wdata[7:0];
            end
            if (b3.mem_write == 2'b01) begin
                m3[b3.mem_addr] <= b3.mem_wdata[15:8];
                m3[a3n]         <= b3.mem_wdata[7:0];
            end
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    int          lat1, lat3, nw1, nw3;
    logic [15:0] rd1, rd3, wa1, wv1, wa3, wv3;
    logic        st_pre, st_at, rdy_c1, e1;
    task automatic drive(input logic w, input logic bt, input logic sg, input logic [15:0] a, input logic [15:0] wd);
        b1.req_write = w;  b1.req_byte = bt; b1.req_signed = sg; b1.req_addr = a; b1.req_wdata = wd;
        b3.req_write = w;  b3.req_byte = bt; b3.req_signed = sg; b3.req_addr = a; b3.req_wdata = wd;
        b1.req_valid = 1'b1;
        b3.req_valid = 1'b1;
    endtask
    task automatic run(input string tag, input logic w, input logic bt, input logic sg, input logic [15:0] a,
                       input logic [15:0] wd, input int l1e, input int l3e, input logic [15:0] rde, input int nwe);
        logic d1, d3;
        d1 = 1'b0; d3 = 1'b0; lat1 = 0; lat3 = 0; nw1 = 0; nw3 = 0;
        st_pre = 1'b1; st_at = 1'b1; rdy_c1 = 1'b1; e1 = 1'b0;
        chk({tag, "_ready"}, b1.req_ready, 1);
        drive(w, bt, sg, a, wd);
        for (int c = 1; c <= 12 && !(d1 && d3); c++) begin
            @(posedge clk); #1;
            if (c == 1) rdy_c1 = b1.req_ready;
            if (b1.mem_write == 2'b01) begin nw1++; wa1 = b1.mem_addr; wv1 = b1.mem_wdata; end
            if (b3.mem_write == 2'b01) begin nw3++; wa3 = b3.mem_addr; wv3 = b3.mem_wdata; end
            if (!d1 && b1.resp_valid) begin
                d1 = 1'b1; lat1 = c; rd1 = b1.resp_rdata; st_at = b1.stall;
`ifdef ALIGN_CHECK_EN
                e1 = b1.resp_err;
`endif
                b1.req_valid = 1'b0;
            end else if (!d1) st_pre &= b1.stall;
            if (!d3 && b3.resp_valid) begin
                d3 = 1'b1; lat3 = c; rd3 = b3.resp_rdata;
                b3.req_valid = 1'b0;
            end
        end
        b1.req_valid = 1'b0;
        b3.req_valid = 1'b0;
        chk({tag, "_lat1"}, lat1, l1e);
        chk({tag, "_lat3"}, lat3, l3e);
        chk({tag, "_nwr1"}, nw1, nwe);
        chk({tag, "_nwr3"}, nw3, nwe);
        if (!w) chk({tag, "_rdata1"}, rd1, rde);
        if (!w) chk({tag, "_rdata3"}, rd3, rde);
        @(posedge clk); #1;
    endtask
    int quiet;
    initial begin
        b1.req_valid = 1'b0; b3.req_valid = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        b1.req_valid = 1'b0; b3.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_write", b1.mem_write, 0);
        chk("rst_mem_addr", b1.mem_addr, 0);
        chk("rst_resp_valid", b1.resp_valid, 0);
        chk("rst_resp_rdata", b3.resp_rdata, 0);
        init = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_ready", b1.req_ready, 1);
        run("ld_w0", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0, 2, 4, 16'h2BCD, 0);
        chk("ld_w0_stall_pre", st_pre, 1);
        chk("ld_w0_stall_resp", st_at, 0);
        chk("ld_w0_ready_busy", rdy_c1, 0);
        run("st_w10", 1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, 2, 2, 16'h0, 1);
        chk("st_w10_addr1", wa1, 16'h0010);
        chk("st_w10_data1", wv1, 16'h1234);
        chk("st_w10_data3", wv3, 16'h1234);
        run("ld_w10", 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, 2, 4, 16'h1234, 0);
        run("st_b11", 1'b1, 1'b1, 1'b0, 16'h0011, 16'hCCAB, 3, 5, 16'h0, 1);
        chk("st_b11_addr1", wa1, 16'h0011);
        chk("st_b11_data1", wv1, 16'hAB5E);
        chk("st_b11_addr3", wa3, 16'h0011);
        chk("st_b11_data3", wv3, 16'hAB5E);
        run("ld_w10b", 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, 2, 4, 16'h12AB, 0);
`ifdef ALIGN_CHECK_EN
        run("ld_mis11", 1'b0, 1'b0, 1'b0, 16'h0011, 16'h0, 1, 1, 16'h0000, 0);
        chk("ld_mis11_err", e1, 1);
        chk("ld_mis11_addr", b1.mem_addr, 16'h0010);
        run("ld_bFFFF", 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0, 2, 4, 16'h0077, 0);
        chk("ld_bFFFF_err", e1, 0);
`else
        run("ld_w11", 1'b0, 1'b0, 1'b0, 16'h0011, 16'h0, 2, 4, 16'hAB5E, 0);
        run("ld_wrap", 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0, 2, 4, 16'h772B, 0);
`endif
        run("ld_b12u", 1'b0, 1'b1, 1'b0, 16'h0012, 16'h0, 2, 4, 16'h005E, 0);
        run("ld_b20s", 1'b0, 1'b1, 1'b1, 16'h0020, 16'h0, 2, 4, 16'hFF80, 0);
        run("ld_b20u", 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 2, 4, 16'h0080, 0);
        drive(1'b1, 1'b1, 1'b0, 16'h0020, 16'h00FF);
        @(posedge clk); #1;
        chk("mid_in_rdwait", b1.mem_write, 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_addr1", b1.mem_addr, 0);
        chk("mid_rst_wdata1", b1.mem_wdata, 0);
        chk("mid_rst_rdata1", b1.resp_rdata, 0);
        chk("mid_rst_addr3", b3.mem_addr, 0);
        b1.req_valid = 1'b0;
        b3.req_valid = 1'b0;
        quiet = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) reset = 1'b0;
            if (b1.mem_write == 2'b01 || b3.mem_write == 2'b01 || b1.resp_valid || b3.resp_valid) quiet++;
        end
        chk("mid_rst_quiet", quiet, 0);
        chk("mid_rst_ready3", b3.req_ready, 1);
        run("after_rst", 1'b0, 1'b1, 1'b1, 16'h0020, 16'h0, 2, 4, 16'hFF80, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
